// File: rtl/edge_pulse_gen.sv
`default_nettype none
// ============================================================================
// Module      : edge_pulse_gen
// Description : Synchronizes a raw asynchronous input, debounces it, and
//               emits one-cycle pulses on accepted rising/falling edges
//               together with the debounced level.
// Revision    : 1.0 - initial release
// ============================================================================
module edge_pulse_gen #(
    parameter int unsigned DEBOUNCE_CYCLES = 4
) (
    input  logic iClk,
    input  logic iReset,
    input  logic iSenal,
    input  logic iEn,
    output logic oFlancosP,
    output logic oFlancosN,
    output logic oFlancosX,
    output logic oNivel
);

    // Terminal count: the input must disagree with the accepted level for
    // this many consecutive cycles, counted from zero, before it is taken.
    localparam logic [7:0] C_CNT_MAX = 8'(DEBOUNCE_CYCLES - 1);

    logic       r_s1;
    logic       r_s2;
    logic       r_lvl;
    logic [7:0] r_cnt;
    logic       r_pulseP;
    logic       r_pulseN;

    logic       w_differs;
    logic       w_accept;
    logic [7:0] w_cntNext;
    logic       w_lvlNext;
    logic       w_pulsePNext;
    logic       w_pulseNNext;

    // Two-flop synchronizer; keeps sampling even while detection is disabled.
    always_ff @(posedge iClk or negedge iReset) begin
        if (!iReset) begin
            r_s1 <= 1'b0;
            r_s2 <= 1'b0;
        end else begin
            r_s1 <= iSenal;
            r_s2 <= r_s1;
        end
    end

    assign w_differs = r_s2 ^ r_lvl;
    // ">=" rather than "==" so a corrupted count can never run past the
    // terminal value and wrap.
    assign w_accept  = iEn & w_differs & (r_cnt >= C_CNT_MAX);

    // Debounce next-state: clear on agreement or disable, count while the
    // input disagrees, accept the new level when the count is exhausted.
    always_comb begin
        w_cntNext    = 8'd0;
        w_lvlNext    = r_lvl;
        w_pulsePNext = 1'b0;
        w_pulseNNext = 1'b0;
        if (iEn && w_differs) begin
            if (w_accept) begin
                w_cntNext    = 8'd0;
                w_lvlNext    = r_s2;
                w_pulsePNext = r_s2;
                w_pulseNNext = ~r_s2;
            end else begin
                w_cntNext = r_cnt + 8'd1;
            end
        end
    end

    // Debounce counter, accepted level and registered edge pulses.
    always_ff @(posedge iClk or negedge iReset) begin
        if (!iReset) begin
            r_cnt    <= 8'd0;
            r_lvl    <= 1'b0;
            r_pulseP <= 1'b0;
            r_pulseN <= 1'b0;
        end else begin
            r_cnt    <= w_cntNext;
            r_lvl    <= w_lvlNext;
            r_pulseP <= w_pulsePNext;
            r_pulseN <= w_pulseNNext;
        end
    end

    assign oFlancosP = r_pulseP;
    assign oFlancosN = r_pulseN;
    assign oFlancosX = r_pulseP | r_pulseN;
    assign oNivel    = r_lvl;

endmodule
`default_nettype wire

// File: doc/edge_pulse_gen.md
EDGE_PULSE_GEN -- requirements
Module: edge_pulse_gen

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 4: number of consecutive cycles the synchronized input must differ from the accepted level before that level changes; legal range 1..255.
REQ-002 iClk  input  1  single system clock; all state changes on its rising edge.
REQ-003 iReset  input  1  asynchronous, active-low reset; iReset=0 clears all state immediately, independent of iClk.
REQ-004 iSenal  input  1  raw asynchronous input (push-button or external signal), unsynchronized.
REQ-005 iEn  input  1  detection enable; 1 = normal operation.
REQ-006 oFlancosP  output  1  one-cycle pulse on an accepted rising edge, feeding the counter input mux positive-edge source.
REQ-007 oFlancosN  output  1  one-cycle pulse on an accepted falling edge, feeding the mux negative-edge source.
REQ-008 oFlancosX  output  1  one-cycle pulse on any accepted edge; equals oFlancosP OR oFlancosN every cycle.
REQ-009 oNivel  output  1  current debounced (accepted) level of iSenal.

Function
REQ-010 The block SHALL pass iSenal through a two-flop synchronizer (s1, s2); only s2 is used downstream.
REQ-011 The block SHALL hold an 8-bit debounce counter cnt and a registered accepted level lvl (drives oNivel).
REQ-012 When iEn=1 and s2==lvl, cnt SHALL load 0 at the next edge and lvl SHALL hold.
REQ-013 When iEn=1, s2!=lvl and cnt<DEBOUNCE_CYCLES-1, cnt SHALL increment by 1 and lvl SHALL hold.
REQ-014 When iEn=1, s2!=lvl and cnt==DEBOUNCE_CYCLES-1, lvl SHALL load s2 and cnt SHALL load 0 on the same edge.
REQ-015 oFlancosP SHALL be registered and high for exactly the cycle after an edge where lvl goes 0->1; low otherwise.
REQ-016 oFlancosN SHALL be registered and high for exactly the cycle after an edge where lvl goes 1->0; low otherwise.
REQ-017 oFlancosP and oFlancosN SHALL never be high in the same cycle.
REQ-018 Latency: if iSenal changes and stays stable, with first capture into s1 at edge k, lvl and the matching pulse SHALL update at edge k+DEBOUNCE_CYCLES+1.
REQ-019 Glitch rejection: if s2 returns to lvl before cnt reaches DEBOUNCE_CYCLES-1, cnt SHALL clear, lvl SHALL hold, and no pulse SHALL occur.
REQ-020 With DEBOUNCE_CYCLES=1, lvl SHALL follow s2 one edge later, and each s2 transition SHALL produce one pulse.
REQ-021 When iEn=0, cnt SHALL be held at 0, lvl SHALL hold, all pulse outputs SHALL be 0, and the synchronizer SHALL keep sampling.
REQ-022 On iEn going 0->1 with s2!=lvl, debounce SHALL start from cnt=0, giving a full DEBOUNCE_CYCLES qualification.
REQ-023 cnt SHALL never exceed DEBOUNCE_CYCLES-1 and SHALL never wrap.

Reset
REQ-024 While iReset=0: s1, s2, lvl, cnt SHALL be 0, and oFlancosP/N/X and oNivel SHALL be 0.
REQ-025 Reset asserted mid-debounce SHALL abort the qualification; no pulse SHALL be emitted for the interrupted edge.
REQ-026 If iSenal=1 at reset release, the block SHALL treat it as a rising edge: one oFlancosP pulse after normal latency.

Verification
REQ-027 DEBOUNCE_CYCLES=4, iEn=1, iSenal 0->1 captured at edge k, held -> oNivel=1 and oFlancosP=oFlancosX=1 for one cycle from edge k+5; oFlancosN stays 0.
REQ-028 From lvl=1, iSenal 1->0 held -> single oFlancosN/oFlancosX pulse at k+5, oNivel=0; oFlancosP stays 0.
REQ-029 lvl=0, iSenal high for 3 cycles, then low -> no pulse, oNivel stays 0, cnt returns to 0.
REQ-030 iEn=0 while iSenal toggles every 10 cycles -> all pulses 0, oNivel constant; iEn=1 with iSenal high -> oFlancosP pulse 4 edges after enable with s2=1.
REQ-031 iReset=0 asserted mid-qualification (cnt=2) and released with iSenal=0 -> outputs 0 immediately (async), no pulse afterwards.
REQ-032 DEBOUNCE_CYCLES=1, iSenal toggled every 3 cycles -> one alternating P/N pulse per toggle, 2 edges after capture; oFlancosX = P|N throughout.
